// File: rtl/jtcus30_dcout.sv
// jtcus30_dcout
//   Output conditioner for the CUS30 stereo DAC. Converts the unsigned 11-bit
//   left/right frame sums into signed 16-bit audio: DC-blocking high-pass
//   (or fixed mid-point removal), 4.4 gain, and saturation. A single datapath
//   is shared between the two channels and sequenced by a five-state FSM.
//
// Parameters
//   POLE  high-pass pole shift, leak term is yprev >>> POLE (4..12)
//   MID   offset removed in bypass mode (mid-scale 1024 << 4)
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   sample_stb  one-cycle pulse, snd_l/snd_r carry a new frame sum
//   snd_l/r     unsigned 11-bit channel sums
//   hpf_en      1 = DC blocker, 0 = subtract MID
//   gain        unsigned 4.4 gain (16 = unity)
//   snd_lo/ro   signed 16-bit outputs, held between sample_out pulses
//   sample_out  one-cycle pulse when snd_lo/snd_ro update
//   ovr         pulses while an already pending sample is being overwritten
module jtcus30_dcout #(
  parameter int POLE = 7,
  parameter int MID  = 16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_stb,
  input  logic [10:0]        snd_l,
  input  logic [10:0]        snd_r,
  input  logic               hpf_en,
  input  logic [7:0]         gain,
  output logic signed [15:0] snd_lo,
  output logic signed [15:0] snd_ro,
  output logic               sample_out,
  output logic               ovr
);

  typedef enum logic [2:0] {IDLE, LH, LG, RH, RG} state_t;

  state_t state_reg, state_next;

  // working copy of the frame being processed
  logic [10:0] xl_reg, xr_reg;

  // one-deep pending buffer for strobes that arrive while busy
  logic [10:0] pend_l_reg, pend_r_reg;
  logic        pend_valid_reg;

  // per-channel filter state, index 0 = left, 1 = right
  logic signed [16:0] xprev_reg [2];
  logic signed [19:0] yprev_reg [2];

  logic signed [19:0] y_reg;      // filter result waiting for the gain stage
  logic signed [15:0] stage_reg;  // left output held until right is ready

  // ---------------------------------------------------------------------------
  // High-pass / bypass stage (active in LH and RH)
  // ---------------------------------------------------------------------------
  logic               ch;
  logic [10:0]        x_sel;
  logic signed [16:0] x_cur;
  logic signed [16:0] xprev_sel;
  logic signed [19:0] yprev_sel;
  logic signed [19:0] leak;
  logic signed [20:0] diff21;
  logic signed [20:0] sum21;
  logic signed [20:0] byp21;
  logic signed [19:0] y_sat;
  logic signed [19:0] y_new;

  assign ch        = (state_reg == RH);
  assign x_sel     = ch ? xr_reg : xl_reg;
  assign x_cur     = {2'b00, x_sel, 4'b0000};
  assign xprev_sel = xprev_reg[ch];
  assign yprev_sel = yprev_reg[ch];
  assign leak      = yprev_sel >>> POLE;
  assign diff21    = {{4{x_cur[16]}}, x_cur} - {{4{xprev_sel[16]}}, xprev_sel};
  assign sum21     = {yprev_sel[19], yprev_sel} + diff21 - {leak[19], leak};
  assign byp21     = {{4{x_cur[16]}}, x_cur} - 21'(MID);

  always_comb begin
    y_sat = sum21[19:0];
    if (sum21[20] != sum21[19]) begin
      y_sat = sum21[20] ? 20'sh80000 : 20'sh7FFFF;
    end
  end

  // bypass result always fits in 20 bits, so no saturation needed there
  assign y_new = hpf_en ? y_sat : byp21[19:0];

  // ---------------------------------------------------------------------------
  // Gain stage (active in LG and RG)
  // ---------------------------------------------------------------------------
  logic signed [8:0]  gain9;
  logic signed [28:0] prod;
  logic signed [28:0] prod_sh;
  logic signed [15:0] out_sat;

  assign gain9   = {1'b0, gain};
  assign prod    = 29'(y_reg) * 29'(gain9);
  assign prod_sh = prod >>> 4;

  always_comb begin
    out_sat = prod_sh[15:0];
    if (!prod_sh[28] && (|prod_sh[27:15])) begin
      out_sat = 16'sh7FFF;
    end else if (prod_sh[28] && !(&prod_sh[27:15])) begin
      out_sat = 16'sh8000;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic take_next;  // RG will start another frame right away

  assign take_next = pend_valid_reg || sample_stb;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sample_stb) state_next = LH;
      LH:      state_next = LG;
      LG:      state_next = RH;
      RH:      state_next = RG;
      RG:      state_next = take_next ? LH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Overwrite indication follows the strobe directly so it lines up with the
  // cycle in which the older pending frame is lost.
  assign ovr = !rst && sample_stb && pend_valid_reg && (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      xl_reg         <= '0;
      xr_reg         <= '0;
      pend_l_reg     <= '0;
      pend_r_reg     <= '0;
      pend_valid_reg <= 1'b0;
      y_reg          <= '0;
      stage_reg      <= '0;
      snd_lo         <= '0;
      snd_ro         <= '0;
      sample_out     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        xprev_reg[i] <= '0;
        yprev_reg[i] <= '0;
      end
    end else begin
      state_reg  <= state_next;
      sample_out <= 1'b0;

      // strobes while busy go to the pending buffer, newest wins;
      // in RG the strobe is consumed directly by the next frame instead
      if (sample_stb && (state_reg != IDLE) && (state_reg != RG)) begin
        pend_l_reg     <= snd_l;
        pend_r_reg     <= snd_r;
        pend_valid_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (sample_stb) begin
            xl_reg <= snd_l;
            xr_reg <= snd_r;
          end
        end
        LH, RH: begin
          y_reg         <= y_new;
          xprev_reg[ch] <= x_cur;
          yprev_reg[ch] <= hpf_en ? y_new : 20'sd0;
        end
        LG: begin
          stage_reg <= out_sat;
        end
        RG: begin
          snd_lo         <= stage_reg;
          snd_ro         <= out_sat;
          sample_out     <= 1'b1;
          pend_valid_reg <= 1'b0;
          if (sample_stb) begin
            xl_reg <= snd_l;
            xr_reg <= snd_r;
          end else if (pend_valid_reg) begin
            xl_reg <= pend_l_reg;
            xr_reg <= pend_r_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
